// File: rtl/cpu_defs_pkg.sv
// -----------------------------------------------------------------------------
// cpu_defs_pkg
// Shared definitions for the hardwired control unit:
//   - opcode constants of the register ALU instruction set
//   - IR field positions (opcode, ra, rb, rc)
//   - sequencer state enum and opcode class enum
//   - classify(): maps an opcode to the execute-phase micro-sequence it needs
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package cpu_defs_pkg;

   localparam int OPCODE_W = 5;
   localparam int IR_REG_W = 4;

   // IR field positions (LSB of each field)
   localparam int IR_OP_LSB = 27;
   localparam int IR_RA_LSB = 23;
   localparam int IR_RB_LSB = 19;
   localparam int IR_RC_LSB = 15;

   localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
   localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
   localparam logic [OPCODE_W-1:0] OP_SHR  = 5'b00111;
   localparam logic [OPCODE_W-1:0] OP_SHRA = 5'b01000;
   localparam logic [OPCODE_W-1:0] OP_SHL  = 5'b01001;
   localparam logic [OPCODE_W-1:0] OP_ROR  = 5'b01010;
   localparam logic [OPCODE_W-1:0] OP_ROL  = 5'b01011;
   localparam logic [OPCODE_W-1:0] OP_MUL  = 5'b01111;
   localparam logic [OPCODE_W-1:0] OP_DIV  = 5'b10000;
   localparam logic [OPCODE_W-1:0] OP_NEG  = 5'b10010;
   localparam logic [OPCODE_W-1:0] OP_NOT  = 5'b10011;
   localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
   localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_T0,
      ST_T1,
      ST_T2,
      ST_T3,
      ST_T4,
      ST_T5,
      ST_T6,
      ST_HALT
   } state_t;

   typedef enum logic [2:0] {
      CL_BINARY,   // two register operands, result to ra
      CL_UNARY,    // one register operand (rb), result to ra
      CL_MULDIV,   // ra x rb, 64-bit result to HI/LO
      CL_NOP,
      CL_HALT,
      CL_ILLEGAL
   } op_class_t;

   function automatic op_class_t classify(input logic [OPCODE_W-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
         OP_SHRA, OP_SHL, OP_ROR, OP_ROL:        return CL_BINARY;
         OP_NEG, OP_NOT:                         return CL_UNARY;
         OP_MUL, OP_DIV:                         return CL_MULDIV;
         OP_NOP:                                 return CL_NOP;
         OP_HALT:                                return CL_HALT;
         default:                                return CL_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// -----------------------------------------------------------------------------
// reg_select_decoder
// Binary-to-one-hot register select with enable; all zeros when disabled.
// Ports:
//   i_sel    [SEL_W-1:0]  register index
//   i_en                  enable
//   o_onehot [N-1:0]      one-hot select (bit i_sel set when enabled)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module reg_select_decoder #(
   parameter int SEL_W = 4,
   parameter int N     = 16
) (
   input  logic [SEL_W-1:0] i_sel,
   input  logic             i_en,
   output logic [N-1:0]     o_onehot
);

   always_comb begin
      // NOTE: default-assign every always_comb output first so no path leaves it unassigned (no latch).
      o_onehot = '0;
      if (i_en) begin
         o_onehot[i_sel] = 1'b1;
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Hardwired Moore control unit for the DataPath block. Fetch runs T0..T2,
// execute runs T3..T6 for register ALU instructions. Strobes are a pure decode
// of the registered state and the IR read back from the datapath; the datapath
// captures on the posedge that ends each state.
//
// Ports:
//   clock, clear            clock; synchronous active-high reset
//   start                   leave IDLE and begin fetching
//   stop                    halt at the next instruction boundary (sticky)
//   mem_rdy                 memory data valid (ends the T1 wait)
//   ir [31:0]               IR contents from the datapath
//   pc_out .. lo_in         datapath strobes
//   alu_op [OPW-1:0]        ALU opcode in T4, else 0
//   reg_in/reg_out [NREGS]  one-hot register load / bus-drive enables
//   running                 high outside IDLE and HALT
//   illegal_op              one-cycle pulse on an undefined opcode
//   instr_count [31:0]      completed instructions (only with SEQ_INSTR_COUNT_EN)
//
// Build option: define SEQ_INSTR_COUNT_EN to add the instr_count port/counter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module control_sequencer
   import cpu_defs_pkg::*;
#(
   parameter int NREGS = 16,
   parameter int OPW   = 5
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic             stop,
   input  logic             mem_rdy,
   input  logic [31:0]      ir,
   output logic             pc_out,
   output logic             mar_in,
   output logic             inc_pc,
   output logic             pc_in,
   output logic             read,
   output logic             mdr_in,
   output logic             mdr_out,
   output logic             ir_in,
   output logic             y_in,
   output logic             z_in,
   output logic             zlow_out,
   output logic             zhigh_out,
   output logic             hi_in,
   output logic             lo_in,
   output logic [OPW-1:0]   alu_op,
   output logic [NREGS-1:0] reg_in,
   output logic [NREGS-1:0] reg_out,
   output logic             running,
   output logic             illegal_op
`ifdef SEQ_INSTR_COUNT_EN
   ,
   output logic [31:0]      instr_count
`endif
);

   state_t               r_state;
   logic                 r_stop_pend;

   logic [OPCODE_W-1:0]  w_opcode;
   logic [IR_REG_W-1:0]  w_ra;
   logic [IR_REG_W-1:0]  w_rb;
   logic [IR_REG_W-1:0]  w_rc;
   op_class_t            w_class;
   logic                 w_stop_pend;
   logic                 w_instr_end;
   state_t               w_end_state;
   logic                 w_rin_en;
   logic                 w_rout_en;
   logic [IR_REG_W-1:0]  w_rout_sel;
   logic                 w_ir_unused;

   assign w_opcode    = ir[IR_OP_LSB +: OPCODE_W];
   assign w_ra        = ir[IR_RA_LSB +: IR_REG_W];
   assign w_rb        = ir[IR_RB_LSB +: IR_REG_W];
   assign w_rc        = ir[IR_RC_LSB +: IR_REG_W];
   assign w_ir_unused = ^ir[IR_RC_LSB-1:0];
   assign w_class     = classify(w_opcode);

   // A stop raised in the boundary cycle itself is honoured at that boundary.
   assign w_stop_pend = r_stop_pend | stop;
   assign w_end_state = w_stop_pend ? ST_HALT : ST_T0;

   // Instruction boundaries; HALT opcode is not a completed instruction.
   assign w_instr_end = ((r_state == ST_T3) && ((w_class == CL_NOP) || (w_class == CL_ILLEGAL)))
                     || ((r_state == ST_T5) && (w_class != CL_MULDIV))
                     ||  (r_state == ST_T6);

   assign running = (r_state != ST_IDLE) && (r_state != ST_HALT);

   // ---------------------------------------------------------------------------
   // State register and sticky stop request
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      // NOTE: clear is sampled on the clock edge (synchronous reset); all state uses <= so every flop sees pre-edge values.
      if (clear) begin
         r_state     <= ST_IDLE;
         r_stop_pend <= 1'b0;
      end else begin
         if (w_instr_end) begin
            r_stop_pend <= 1'b0;
         end else if (stop) begin
            r_stop_pend <= 1'b1;
         end

         case (r_state)
            ST_IDLE: if (start) r_state <= ST_T0;
            ST_T0:   r_state <= ST_T1;
            ST_T1:   if (mem_rdy) r_state <= ST_T2;
            ST_T2:   r_state <= ST_T3;
            ST_T3: begin
               case (w_class)
                  CL_HALT:                       r_state <= ST_HALT;
                  CL_BINARY, CL_UNARY, CL_MULDIV: r_state <= ST_T4;
                  default:                       r_state <= w_end_state;
               endcase
            end
            ST_T4:   r_state <= ST_T5;
            ST_T5:   r_state <= (w_class == CL_MULDIV) ? ST_T6 : w_end_state;
            ST_T6:   r_state <= w_end_state;
            ST_HALT: r_state <= ST_HALT;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Strobe decode
   // ---------------------------------------------------------------------------
   always_comb begin
      pc_out     = 1'b0;
      mar_in     = 1'b0;
      inc_pc     = 1'b0;
      pc_in      = 1'b0;
      read       = 1'b0;
      mdr_in     = 1'b0;
      mdr_out    = 1'b0;
      ir_in      = 1'b0;
      y_in       = 1'b0;
      z_in       = 1'b0;
      zlow_out   = 1'b0;
      zhigh_out  = 1'b0;
      hi_in      = 1'b0;
      lo_in      = 1'b0;
      alu_op     = '0;
      illegal_op = 1'b0;
      w_rin_en   = 1'b0;
      w_rout_en  = 1'b0;
      w_rout_sel = w_rb;

      case (r_state)
         ST_T0: begin
            pc_out = 1'b1;
            mar_in = 1'b1;
            inc_pc = 1'b1;
            z_in   = 1'b1;
         end
         ST_T1: begin
            // Held through memory wait; PC reloads the same Z value each cycle.
            zlow_out = 1'b1;
            pc_in    = 1'b1;
            read     = 1'b1;
            mdr_in   = 1'b1;
         end
         ST_T2: begin
            mdr_out = 1'b1;
            ir_in   = 1'b1;
         end
         ST_T3: begin
            case (w_class)
               CL_BINARY, CL_UNARY: begin
                  w_rout_en = 1'b1;
                  y_in      = 1'b1;
               end
               CL_MULDIV: begin
                  w_rout_en  = 1'b1;
                  w_rout_sel = w_ra;
                  y_in       = 1'b1;
               end
               CL_ILLEGAL: illegal_op = 1'b1;
               default: ;
            endcase
         end
         ST_T4: begin
            case (w_class)
               CL_BINARY: begin
                  w_rout_en  = 1'b1;
                  w_rout_sel = w_rc;
                  alu_op     = OPW'(w_opcode);
                  z_in       = 1'b1;
               end
               CL_UNARY: begin
                  alu_op = OPW'(w_opcode);
                  z_in   = 1'b1;
               end
               CL_MULDIV: begin
                  w_rout_en = 1'b1;
                  alu_op    = OPW'(w_opcode);
                  z_in      = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T5: begin
            case (w_class)
               CL_BINARY, CL_UNARY: begin
                  zlow_out = 1'b1;
                  w_rin_en = 1'b1;
               end
               CL_MULDIV: begin
                  zlow_out = 1'b1;
                  lo_in    = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T6: begin
            zhigh_out = 1'b1;
            hi_in     = (w_class == CL_MULDIV);
         end
         default: ;
      endcase
   end

   reg_select_decoder #(.SEL_W(IR_REG_W), .N(NREGS)) u_reg_in_dec (
      .i_sel    (w_ra),
      .i_en     (w_rin_en),
      .o_onehot (reg_in)
   );

   reg_select_decoder #(.SEL_W(IR_REG_W), .N(NREGS)) u_reg_out_dec (
      .i_sel    (w_rout_sel),
      .i_en     (w_rout_en),
      .o_onehot (reg_out)
   );

`ifdef SEQ_INSTR_COUNT_EN
   logic [31:0] r_instr_count;

   always_ff @(posedge clock) begin
      if (clear) begin
         r_instr_count <= '0;
      end else if (w_instr_end) begin
         r_instr_count <= r_instr_count + 32'd1;
      end
   end

   assign instr_count = r_instr_count;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
`timescale 1ns/1ps
module tb_control_sequencer;

   // ---------------------------------------------------------------------------
   // DUT hookup
   // ---------------------------------------------------------------------------
   logic        clock = 1'b0;
   logic        clear, start, stop, mem_rdy;
   logic [31:0] ir;
   logic        pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
   logic        y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in;
   logic [4:0]  alu_op;
   logic [15:0] reg_in, reg_out;
   logic        running, illegal_op;
`ifdef SEQ_INSTR_COUNT_EN
   logic [31:0] instr_count;
`endif

   control_sequencer #(.NREGS(16), .OPW(5)) dut (
      .clock      (clock),
      .clear      (clear),
      .start      (start),
      .stop       (stop),
      .mem_rdy    (mem_rdy),
      .ir         (ir),
      .pc_out     (pc_out),
      .mar_in     (mar_in),
      .inc_pc     (inc_pc),
      .pc_in      (pc_in),
      .read       (read),
      .mdr_in     (mdr_in),
      .mdr_out    (mdr_out),
      .ir_in      (ir_in),
      .y_in       (y_in),
      .z_in       (z_in),
      .zlow_out   (zlow_out),
      .zhigh_out  (zhigh_out),
      .hi_in      (hi_in),
      .lo_in      (lo_in),
      .alu_op     (alu_op),
      .reg_in     (reg_in),
      .reg_out    (reg_out),
      .running    (running),
      .illegal_op (illegal_op)
`ifdef SEQ_INSTR_COUNT_EN
      ,
      .instr_count(instr_count)
`endif
   );

   always #5 clock = ~clock;

   // ---------------------------------------------------------------------------
   // Output bundle and stimulus step
   // ---------------------------------------------------------------------------
   typedef struct packed {
      logic        pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
      logic        y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in;
      logic [4:0]  alu_op;
      logic [15:0] reg_in, reg_out;
      logic        running, illegal_op;
   } outs_t;

   typedef struct packed {
      logic        clr, st, sp, rdy;
      logic [31:0] irv;
      outs_t       e;     // outputs expected during this cycle
      logic [31:0] cnt;   // instruction count expected during this cycle
   } step_t;

   outs_t act;
   assign act = {pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
                 y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in,
                 alu_op, reg_in, reg_out, running, illegal_op};

   step_t sched[$];
   outs_t act_log[$];
   step_t cur;
   int    cur_idx;
   bit    cmp_en = 1'b0;
   int    n_vec  = 0;
   int    n_err  = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model: each instruction expands into its list of per-cycle
   // output sets, straight from the micro-step table of the instruction set.
   // ---------------------------------------------------------------------------
   int          m_idx, m_clr_at, m_stop_at;
   bit          m_aborted, m_stop_pend;
   logic [31:0] m_count = 0;

   function automatic logic [31:0] mk(input int op, input int ra, input int rb, input int rc);
      return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'b0};
   endfunction

   function automatic logic [15:0] sel(input logic [3:0] r);
      logic [15:0] one;
      one = 16'h0001;
      return one << r;
   endfunction

   function automatic outs_t busy();
      outs_t o;
      o = '0;
      o.running = 1'b1;
      return o;
   endfunction

   task automatic push_raw(input logic clr, input logic st, input logic sp, input logic rdy,
                           input logic [31:0] irv, input outs_t e);
      step_t s;
      s.clr = clr; s.st = st; s.sp = sp; s.rdy = rdy; s.irv = irv; s.e = e; s.cnt = m_count;
      sched.push_back(s);
      if (sp) m_stop_pend = 1'b1;
      if (clr) begin
         m_count     = 0;
         m_stop_pend = 1'b0;
      end
   endtask

   // One cycle inside an instruction; start is randomised (must be ignored).
   task automatic push_step(input logic rdy, input logic [31:0] irv, input outs_t e);
      logic c;
      if (m_aborted) return;
      c = (m_idx == m_clr_at);
      push_raw(c, 1'($urandom_range(0, 1)), (m_idx == m_stop_at), rdy, irv, e);
      if (c) m_aborted = 1'b1;
      m_idx++;
   endtask

   // Plans one instruction starting in T0. halted reports whether HALT follows.
   task automatic plan_instr(input logic [31:0] irv, input int waits, input int clr_at,
                             input int stop_at, output bit halted);
      outs_t      o;
      logic [4:0] op;
      logic [3:0] ra, rb, rc;
      bit         bin, un, md;
      op = irv[31:27]; ra = irv[26:23]; rb = irv[22:19]; rc = irv[18:15];
      bin = int'(op) inside {3, 4, 5, 6, 7, 8, 9, 10, 11};
      un  = int'(op) inside {18, 19};
      md  = int'(op) inside {15, 16};
      m_idx = 0; m_clr_at = clr_at; m_stop_at = stop_at; m_aborted = 1'b0;
      halted = 1'b0;

      o = busy(); o.pc_out = 1; o.mar_in = 1; o.inc_pc = 1; o.z_in = 1;
      push_step(1'($urandom_range(0, 1)), irv, o);
      for (int w = 0; w <= waits; w++) begin
         o = busy(); o.zlow_out = 1; o.pc_in = 1; o.read = 1; o.mdr_in = 1;
         push_step(w == waits, irv, o);
      end
      o = busy(); o.mdr_out = 1; o.ir_in = 1;
      push_step(1'($urandom_range(0, 1)), irv, o);

      o = busy();
      if (op == 5'd27) begin
         push_step(1'b1, irv, o);
         halted = !m_aborted;
         return;
      end else if (bin || un) begin
         o.reg_out = sel(rb); o.y_in = 1;
         push_step(1'b1, irv, o);
         o = busy(); o.alu_op = op; o.z_in = 1; o.reg_out = bin ? sel(rc) : 16'h0000;
         push_step(1'b1, irv, o);
         o = busy(); o.zlow_out = 1; o.reg_in = sel(ra);
         push_step(1'b1, irv, o);
      end else if (md) begin
         o.reg_out = sel(ra); o.y_in = 1;
         push_step(1'b1, irv, o);
         o = busy(); o.reg_out = sel(rb); o.alu_op = op; o.z_in = 1;
         push_step(1'b1, irv, o);
         o = busy(); o.zlow_out = 1; o.lo_in = 1;
         push_step(1'b1, irv, o);
         o = busy(); o.zhigh_out = 1; o.hi_in = 1;
         push_step(1'b1, irv, o);
      end else begin
         o.illegal_op = (op != 5'd26);
         push_step(1'b1, irv, o);
      end

      if (!m_aborted) begin
         m_count     = m_count + 1;
         halted      = m_stop_pend;
         m_stop_pend = 1'b0;
      end
   endtask

   // ---------------------------------------------------------------------------
   // Compare process: every scheduled cycle, away from the active edge
   // ---------------------------------------------------------------------------
   always @(negedge clock) begin
      if (cmp_en) begin
         check($sformatf("step%0d outputs", cur_idx), {11'b0, act}, {11'b0, cur.e});
`ifdef SEQ_INSTR_COUNT_EN
         check($sformatf("step%0d instr_count", cur_idx), {32'b0, instr_count}, {32'b0, cur.cnt});
`endif
         act_log.push_back(act);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   localparam logic [31:0] IR_AND = 32'h2A2B8000;  // AND ra=4 rb=5 rc=7
   outs_t zero_o;
   bit    h;
   int    idx_and, idx_neg, idx_mul, idx_ill, idx_halt, idx_ss_h, idx_ab, idx_hop;
   int    extra_ops[4] = '{6, 7, 8, 11};

   initial begin
      zero_o = '0;
      clear = 1'b1; start = 1'b0; stop = 1'b0; mem_rdy = 1'b0; ir = '0;

      push_raw(1, 0, 0, 1, 32'h0, zero_o);              // reset state
      push_raw(0, 1, 0, 1, IR_AND, zero_o);             // IDLE, start
      idx_and = sched.size(); plan_instr(IR_AND, 0, -1, -1, h);
      idx_neg = sched.size(); plan_instr(mk(18, 5, 0, 9), 0, -1, -1, h);
      idx_mul = sched.size(); plan_instr(mk(15, 3, 2, 6), 3, -1, -1, h);
      idx_ill = sched.size(); plan_instr(mk(31, 1, 2, 3), 1, -1, -1, h);
      plan_instr(mk(26, 0, 0, 0), 0, -1, -1, h);
      plan_instr(mk(9, 15, 14, 13), 1, -1, -1, h);
      plan_instr(mk(16, 0, 15, 1), 2, -1, -1, h);
      plan_instr(mk(19, 12, 11, 0), 0, -1, -1, h);
      foreach (extra_ops[k]) plan_instr(mk(extra_ops[k], k + 8, k + 1, k + 3), 0, -1, -1, h);

      // Sticky stop raised during T1 of ROR: HALT after it completes
      plan_instr(mk(10, 6, 7, 8), 3, -1, 1, h);
      idx_halt = sched.size();
      repeat (3) push_raw(0, 1, 0, 1, 32'h0, zero_o);  // start ignored in HALT
      push_raw(1, 0, 0, 1, 32'h0, zero_o);
      push_raw(0, 0, 0, 1, 32'h0, zero_o);

      // Single step: start and stop together in IDLE
      push_raw(0, 1, 1, 1, mk(4, 2, 3, 4), zero_o);
      plan_instr(mk(4, 2, 3, 4), 0, -1, -1, h);
      idx_ss_h = sched.size();
      repeat (3) push_raw(0, 1, 0, 1, 32'h0, zero_o);
      push_raw(1, 0, 0, 1, 32'h0, zero_o);
      push_raw(0, 0, 0, 1, 32'h0, zero_o);

      // clear during T4 of ADD
      push_raw(0, 1, 0, 1, mk(3, 1, 2, 3), zero_o);
      plan_instr(mk(3, 1, 2, 3), 0, 4, -1, h);
      idx_ab = sched.size();
      repeat (2) push_raw(0, 0, 0, 1, mk(3, 1, 2, 3), zero_o);

      // HALT opcode
      push_raw(0, 1, 0, 1, mk(27, 0, 0, 0), zero_o);
      plan_instr(mk(27, 0, 0, 0), 0, -1, -1, h);
      idx_hop = sched.size();
      repeat (2) push_raw(0, 1, 0, 1, 32'h0, zero_o);
      push_raw(1, 0, 0, 1, 32'h0, zero_o);
      push_raw(0, 0, 0, 1, 32'h0, zero_o);

      repeat (2) @(posedge clock);
      #1;
      foreach (sched[i]) begin
         clear = sched[i].clr; start = sched[i].st; stop = sched[i].sp;
         mem_rdy = sched[i].rdy; ir = sched[i].irv;
         cur = sched[i]; cur_idx = i; cmp_en = 1'b1;
         @(posedge clock);
         #1;
      end
      cmp_en = 1'b0;

      // Hand-computed expectations pinning specific cycles
      check("log_length", 64'(act_log.size()), 64'(sched.size()));
      if (act_log.size() == sched.size()) begin
         check("and_t3", {act_log[idx_and+3].y_in, act_log[idx_and+3].reg_out}, {1'b1, 16'h0020});
         check("and_t4", {act_log[idx_and+4].z_in, act_log[idx_and+4].alu_op, act_log[idx_and+4].reg_out},
                         {1'b1, 5'b00101, 16'h0080});
         check("and_t5", {act_log[idx_and+5].zlow_out, act_log[idx_and+5].reg_in}, {1'b1, 16'h0010});
         check("and_7th_edge_t0", {act_log[idx_and+6].pc_out, act_log[idx_and+6].mar_in}, 2'b11);
         check("neg_t3", act_log[idx_neg+3].reg_out, 16'h0001);
         check("neg_t4", {act_log[idx_neg+4].alu_op, act_log[idx_neg+4].reg_out}, {5'b10010, 16'h0000});
         check("neg_t5", act_log[idx_neg+5].reg_in, 16'h0020);
         for (int k = 1; k <= 4; k++)
            check($sformatf("mul_t1_wait%0d", k), {act_log[idx_mul+k].read, act_log[idx_mul+k].mdr_in}, 2'b11);
         check("mul_t5_lo", act_log[idx_mul+8].lo_in, 1'b1);
         check("mul_t6_hi", act_log[idx_mul+9].hi_in, 1'b1);
         check("mul_10_cycles", act_log[idx_mul+10].pc_out, 1'b1);
         begin
            int          pulses;
            logic [17:0] wb;
            pulses = 0; wb = '0;
            for (int k = idx_ill; k <= idx_ill + 5; k++) begin
               pulses += int'(act_log[k].illegal_op);
               wb |= {act_log[k].reg_in, act_log[k].hi_in, act_log[k].lo_in};
            end
            check("illegal_pulse_count", 64'(pulses), 64'd1);
            check("illegal_no_writeback", wb, 18'h0);
            check("illegal_next_t0", act_log[idx_ill+5].pc_out, 1'b1);
         end
         check("sticky_stop_halt", act_log[idx_halt].running, 1'b0);
         check("single_step_halt", act_log[idx_ss_h+2].running, 1'b0);
         check("abort_idle", {11'b0, act_log[idx_ab]}, 64'h0);
         check("halt_opcode", act_log[idx_hop].running, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit for the DataPath block.
- Sequences fetch (T0–T2) and execute (T3–T6) for register ALU instructions.
- Drives every datapath control strobe from a Moore FSM, replacing the hand-driven bench sequence.
- Sits between the memory interface and DataPath. Reads IR contents back from the datapath and emits one-hot register select vectors.

Parameters:
- NREGS, 16, number of general registers; width of the reg_in/reg_out vectors.
- OPW, 5, opcode width.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- clear  in  1  reset; synchronous, active-high.
- start  in  1  leave IDLE and begin fetching at the current PC.
- stop  in  1  request halt at the next instruction boundary; sticky until honoured.
- mem_rdy  in  1  memory data valid on Mdatain this cycle.
- ir  in  32  IR contents from the datapath.
- pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in, y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in  out  1 each  datapath strobes.
- alu_op  out  5  ALU opcode; 0 when no ALU op is active.
- reg_in  out  16  one-hot register load enables (R0..R15).
- reg_out  out  16  one-hot register bus drives (R0..R15).
- running  out  1  high in every state except IDLE and HALT.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- IR fields: opcode = ir[31:27], ra = ir[26:23], rb = ir[22:19], rc = ir[18:15].
- Outputs are a pure decode of the registered state and ir; there is no output registering. The datapath captures on the posedge that ends each state.
- Reset: clear high at a posedge forces state IDLE, drops the pending stop, and zeroes the counter. Every output is then 0. clear aborts any in-flight instruction with no partial writeback beyond edges already taken.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT.
- IDLE: start → T0; otherwise stay.
- T0: pc_out, mar_in, inc_pc, z_in → T1.
- T1: zlow_out, pc_in, read, mdr_in.
  - Stays in T1 while mem_rdy = 0. Strobes remain asserted; PC reloads the unchanged Z each cycle, which is harmless.
  - mem_rdy = 1 → T2.
- T2: mdr_out, ir_in → T3.
- T3, decoded on ir:
  - NOP: no strobes; instruction ends.
  - HALT: → HALT.
  - Illegal opcode: pulse illegal_op; instruction ends.
  - Binary ALU op (ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL): reg_out[rb], y_in → T4.
  - Unary op (NEG, NOT): reg_out[rb], y_in → T4.
  - MUL, DIV: reg_out[ra], y_in → T4.
- T4:
  - Binary ALU op: reg_out[rc], alu_op = opcode, z_in.
  - Unary op: alu_op = opcode, z_in; reg_out = 0.
  - MUL/DIV: reg_out[rb], alu_op = opcode, z_in.
  - All cases → T5.
- T5:
  - ALU and unary ops: zlow_out, reg_in[ra]; instruction ends.
  - MUL/DIV: zlow_out, lo_in → T6.
- T6: zhigh_out, hi_in; instruction ends.
- Instruction end: if stop is pending → HALT and clear the pending flag; else → T0.
- Latency: NOP = 4 cycles; ALU and unary ops = 6 cycles; MUL/DIV = 7 cycles; each plus one cycle per mem_rdy wait.
- HALT: all outputs 0, running = 0. Only clear exits HALT; start is ignored.
- start outside IDLE is ignored.
- start and stop high in the same cycle in IDLE: execute exactly one instruction, then HALT (single-step).
- Illegal opcodes never assert reg_in, hi_in or lo_in.
- At most one bit of reg_in and at most one bit of reg_out is set in any cycle.

Optional Feature:
- Macro: SEQ_INSTR_COUNT_EN.
- Defined: adds output instr_count [31:0]. It increments by 1 on each completed instruction, including NOP and illegal, excluding HALT, and wraps 0xFFFFFFFF → 0. clear zeroes it.
- Undefined: port and counter absent; no other behaviour changes.

Decomposition:
- Package cpu_defs_pkg:
  - opcode constants: ADD=00011, SUB=00100, AND=00101, OR=00110, SHR=00111, SHRA=01000, SHL=01001, ROR=01010, ROL=01011, MUL=01111, DIV=10000, NEG=10010, NOT=10011, NOP=11010, HALT=11011.
  - state enum.
  - IR field bit positions.
- Sub-module reg_select_decoder: 4-to-16 one-hot decoder with enable. Instantiated twice, once for reg_in and once for reg_out.

Test Plan:
- clear, then start with mem_rdy = 1 and ir = 0x2A2B8000 (AND, ra=4, rb=5, rc=7) → T3 reg_out = 0x0020 with y_in; T4 reg_out = 0x0080 with alu_op = 00101 and z_in; T5 reg_in = 0x0010 with zlow_out; T0 again on the 7th edge.
- NEG, ra=5, rb=0 → T3 reg_out = 0x0001; T4 alu_op = 10010 with reg_out = 0; T5 reg_in = 0x0020.
- MUL ra=3 rb=2 with mem_rdy held low 3 cycles in T1 → T1 lasts 4 cycles with read and mdr_in held; T5 lo_in; T6 hi_in; total 10 cycles.
- ir opcode = 11111 → illegal_op is high for exactly 1 cycle; reg_in, hi_in, lo_in stay 0; next state T0.
- start and stop together from IDLE → one instruction completes, then HALT with running = 0; a later start is ignored; clear → IDLE with all outputs 0.
- clear asserted during T4 → next cycle IDLE, all outputs 0, no reg_in pulse; with SEQ_INSTR_COUNT_EN, instr_count = 0.
